// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and angle-scaling helper for the CORDIC
// angle-reduction front end.
package cordic_pkg;

  localparam int unsigned ANGLE_W_DEFAULT = 32;
  localparam int unsigned FRAC_W_DEFAULT  = 11;

  function automatic longint deg(input int unsigned d, input int unsigned frac);
    return longint'(d) << frac;
  endfunction

  localparam longint DEG_90  = deg(90,  FRAC_W_DEFAULT);
  localparam longint DEG_180 = deg(180, FRAC_W_DEFAULT);
  localparam longint DEG_270 = deg(270, FRAC_W_DEFAULT);
  localparam longint DEG_360 = deg(360, FRAC_W_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_FOLD,
    ST_OUT
  } state_e;

endpackage

// File: rtl/cordic_fold.sv
// Folds an angle in [0,360) deg into [-90,+90] deg, flags cos negation and
// reports the quadrant of the unfolded angle.
module cordic_fold
  import cordic_pkg::*;
#(
  parameter int unsigned ANGLE_W = ANGLE_W_DEFAULT,
  parameter int unsigned FRAC_W  = FRAC_W_DEFAULT
) (
  input  logic signed [ANGLE_W:0]   a_i,
  output logic signed [ANGLE_W-1:0] angle_o,
  output logic                      cos_neg_o,
  output logic [1:0]                quadrant_o
);

  localparam int unsigned AW = ANGLE_W + 1;
  localparam logic signed [AW-1:0] D90  = AW'(deg(90,  FRAC_W));
  localparam logic signed [AW-1:0] D180 = AW'(deg(180, FRAC_W));
  localparam logic signed [AW-1:0] D270 = AW'(deg(270, FRAC_W));
  localparam logic signed [AW-1:0] D360 = AW'(deg(360, FRAC_W));

  logic signed [AW-1:0] folded;

  always_comb begin
    folded    = a_i;
    cos_neg_o = 1'b0;
    if (a_i > D270) begin
      folded = a_i - D360;
    end else if (a_i > D90) begin
      folded    = D180 - a_i;
      cos_neg_o = 1'b1;
    end
    angle_o = ANGLE_W'(folded);
  end

  // Quadrants are half-open, so exactly 90/180/270 deg start the next one.
  always_comb begin
    if (a_i >= D270)      quadrant_o = 2'd3;
    else if (a_i >= D180) quadrant_o = 2'd2;
    else if (a_i >= D90)  quadrant_o = 2'd1;
    else                  quadrant_o = 2'd0;
  end

endmodule

// File: rtl/cordic_angle_reduce.sv
// Reduces an arbitrary signed angle to [0,360) by repeated +/-360 steps, then
// folds it into [-90,+90] for a downstream CORDIC with a valid/ready handshake.
module cordic_angle_reduce
  import cordic_pkg::*;
#(
  parameter int unsigned ANGLE_W = ANGLE_W_DEFAULT,
  parameter int unsigned FRAC_W  = FRAC_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ANGLE_W-1:0] in_angle,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ANGLE_W-1:0] out_angle,
  output logic                      out_cos_neg,
  output logic [1:0]                out_quadrant
);

  localparam int unsigned AW = ANGLE_W + 1;
  localparam logic signed [AW-1:0] D360 = AW'(deg(360, FRAC_W));

  state_e                   state_q;
  logic signed [AW-1:0]     a_q;
  logic                     out_valid_q;
  logic signed [ANGLE_W-1:0] out_angle_q;
  logic                     out_cos_neg_q;
  logic [1:0]               out_quadrant_q;

  logic signed [ANGLE_W-1:0] fold_angle;
  logic                      fold_cos_neg;
  logic [1:0]                fold_quadrant;

  cordic_fold #(
    .ANGLE_W (ANGLE_W),
    .FRAC_W  (FRAC_W)
  ) u_fold (
    .a_i        (a_q),
    .angle_o    (fold_angle),
    .cos_neg_o  (fold_cos_neg),
    .quadrant_o (fold_quadrant)
  );

  // One extra bit on a keeps a +/-360 step from wrapping at the input extremes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      a_q            <= '0;
      out_valid_q    <= 1'b0;
      out_angle_q    <= '0;
      out_cos_neg_q  <= 1'b0;
      out_quadrant_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= AW'(in_angle);
            state_q <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          if (a_q >= D360)        a_q <= a_q - D360;
          else if (a_q[AW-1])     a_q <= a_q + D360;
          else                    state_q <= ST_FOLD;
        end
        ST_FOLD: begin
          out_angle_q    <= fold_angle;
          out_cos_neg_q  <= fold_cos_neg;
          out_quadrant_q <= fold_quadrant;
          out_valid_q    <= 1'b1;
          state_q        <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = out_valid_q;
  assign out_angle    = out_angle_q;
  assign out_cos_neg  = out_cos_neg_q;
  assign out_quadrant = out_quadrant_q;

endmodule

// File: tb/tb_cordic_angle_reduce.sv
// Scoreboard bench for cordic_angle_reduce: expected fold results and output
// cycle are queued at acceptance and compared when out_valid first rises.
module tb_cordic_angle_reduce;

  localparam longint D90  = 184320;
  localparam longint D180 = 368640;
  localparam longint D270 = 552960;
  localparam longint D360 = 737280;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_angle;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_angle;
  logic               out_cos_neg;
  logic [1:0]         out_quadrant;

  typedef struct {
    longint ang;
    longint cos_neg;
    longint quad;
    longint cyc;
  } exp_t;

  exp_t        sb[$];
  longint      cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  cordic_angle_reduce #(
    .ANGLE_W (32),
    .FRAC_W  (11)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_angle     (in_angle),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_angle    (out_angle),
    .out_cos_neg  (out_cos_neg),
    .out_quadrant (out_quadrant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Reference: closed-form modulo and correction count, then the fold rules.
  function automatic exp_t model(input longint ang, input longint c0);
    exp_t   e;
    longint r, k;
    r = ang % D360;
    if (r < 0) r += D360;
    k = (ang >= 0) ? ang / D360 : (-ang + D360 - 1) / D360;
    if (r <= D90) begin
      e.ang = r; e.cos_neg = 0;
    end else if (r <= D270) begin
      e.ang = D180 - r; e.cos_neg = 1;
    end else begin
      e.ang = r - D360; e.cos_neg = 0;
    end
    e.quad = r / D90;
    e.cyc  = c0 + k + 3;
    return e;
  endfunction

  logic               prev_valid = 1'b0;
  logic signed [31:0] held_angle;
  logic               held_cos;
  logic [1:0]         held_quad;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (!prev_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_angle",    out_angle,    e.ang);
          check("out_cos_neg",  out_cos_neg,  e.cos_neg);
          check("out_quadrant", out_quadrant, e.quad);
          check("latency_cyc",  cyc,          e.cyc);
        end
      end else begin
        check("stable_angle", out_angle,    held_angle);
        check("stable_cos",   out_cos_neg,  held_cos);
        check("stable_quad",  out_quadrant, held_quad);
      end
      held_angle = out_angle;
      held_cos   = out_cos_neg;
      held_quad  = out_quadrant;
    end
    prev_valid = (out_valid === 1'b1);
  end

  task automatic send(input logic signed [31:0] ang);
    int unsigned waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_angle = ang;
    sb.push_back(model(longint'(ang), cyc));
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_in_ready", in_ready, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) return;
    end
    check("drain_timeout", 0, 1);
  endtask

  logic signed [31:0] vec[$];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_angle  = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid,    0);
    check("rst_out_angle", out_angle,    0);
    check("rst_cos_neg",   out_cos_neg,  0);
    check("rst_quadrant",  out_quadrant, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    vec = '{32'sd61440, 32'sd307200, 32'sd552960, 32'sd819200, -32'sd61440,
            32'sd184320, 32'sd737280, 32'sd0, 32'sd368640, 32'sd184319,
            32'sd552961, -32'sd737280, 32'sh8000_0000, 32'sh7FFF_FFFF};
    for (int i = 0; i < 4; i++) vec.push_back($signed($urandom()));
    foreach (vec[i]) begin
      send(vec[i]);
      drain();
    end

    // Backpressure: outputs must hold and new requests must be ignored.
    out_ready = 1'b0;
    send(32'sd307200);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("stall_valid_seen", out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_angle = $signed($urandom());
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", out_valid, 0);
    check("release_in_ready",  in_ready,  1);
    repeat (5) @(negedge clk);
    check("no_ghost_accept", out_valid, 0);
    send(-32'sd61440);
    drain();

    // Reset in the middle of reduction discards the transaction.
    send(32'sd819200);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", out_valid,    0);
    check("midrst_out_angle", out_angle,    0);
    check("midrst_cos_neg",   out_cos_neg,  0);
    check("midrst_quadrant",  out_quadrant, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    repeat (10) @(negedge clk);
    check("midrst_no_valid", out_valid, 0);

    send(32'sd61440);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
